// File: rtl/pipe_ctrl_if.sv
// Hazard handshake bundle between the pipeline and pipe_ctrl.
// The pipeline side drives requests; the controller returns stall/flush.
interface pipe_ctrl_if #(
   parameter int NSTAGE = 5
);
   logic [NSTAGE-1:0] stallreq;
   logic              redirect;
   logic              enter;
   logic [NSTAGE-1:0] stall;
   logic [NSTAGE-1:0] flush;

   modport master (
      output stallreq, redirect, enter,
      input  stall, flush
   );

   modport slave (
      input  stallreq, redirect, enter,
      output stall, flush
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush resolution, trap drain FSM,
// stall-cycle counter. Optional watchdog enabled by STALL_TIMEOUT_EN.
module pipe_ctrl #(
   parameter int NSTAGE      = 5,
   parameter int REDIR_DEPTH = 2,
   parameter int FLUSH_CYC   = 2,
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 64
) (
   input  logic             clk,
   input  logic             rst,
   pipe_ctrl_if.slave       hz,
   input  logic             cnt_clr_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic             timeout_o
);

   typedef enum logic {RUN, TRAP} state_e;

   localparam logic [3:0] DRAIN_INIT =
      4'((FLUSH_CYC > 1) ? (FLUSH_CYC - 2) : 0);

   state_e            state_q, state_d;
   logic [3:0]        drain_q, drain_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [NSTAGE-1:0] hold;
   logic [NSTAGE-1:0] stall_c;
   logic [NSTAGE-1:0] flush_c;
   logic              trap_act;
   logic              redir_ok;
   logic              unused_req0;

   assign unused_req0 = hz.stallreq[0];

   // hold[i]: some stage at index >= max(i,1) requests a stall
   always_comb begin
      hold = '0;
      hold[NSTAGE-1] = hz.stallreq[NSTAGE-1];
      for (int i = NSTAGE - 2; i >= 1; i--) begin
         hold[i] = hold[i+1] | hz.stallreq[i];
      end
      hold[0] = hold[1];
   end

   assign trap_act = hz.enter | (state_q == TRAP);
   assign redir_ok = hz.redirect & ~hold[REDIR_DEPTH];

   // Resolve trap > redirect > stall into per-register controls
   always_comb begin
      stall_c = '0;
      flush_c = '0;
      if (rst) begin
         stall_c = '0;
      end else if (trap_act) begin
         for (int i = 1; i < NSTAGE; i++) flush_c[i] = 1'b1;
      end else if (redir_ok) begin
         for (int i = 1; i <= REDIR_DEPTH; i++) flush_c[i] = 1'b1;
      end else begin
         stall_c = hold;
         for (int i = 1; i < NSTAGE; i++) begin
            flush_c[i] = hold[i-1] & ~hold[i];
         end
      end
   end

   assign hz.stall = stall_c;
   assign hz.flush = flush_c;

   // Trap drain FSM next state and stall-cycle counter next value
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      unique case (state_q)
         RUN: begin
            if (hz.enter && (FLUSH_CYC > 1)) begin
               state_d = TRAP;
               drain_d = DRAIN_INIT;
            end
         end
         TRAP: begin
            if (hz.enter) begin
               drain_d = DRAIN_INIT;
            end else if (drain_q == 4'd0) begin
               state_d = RUN;
            end else begin
               drain_d = drain_q - 4'd1;
            end
         end
         default: state_d = RUN;
      endcase
      busy_d = (state_d == TRAP);

      cnt_d = cnt_q;
      if (cnt_clr_i) begin
         cnt_d = '0;
      end else if (stall_c[0] && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Register FSM, busy flag and stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         drain_q <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o         = busy_q;
   assign stall_cycles_o = cnt_q;

`ifdef STALL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_q, wd_d;

   // Consecutive-stall count, parks at TIMEOUT so the pulse fires once
   always_comb begin
      wd_d = '0;
      if (stall_c[0]) begin
         if (wd_q == WD_W'(TIMEOUT)) wd_d = wd_q;
         else                        wd_d = wd_q + WD_W'(1);
      end
   end

   // Register the watchdog count
   always_ff @(posedge clk) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end

   assign timeout_o = stall_c[0] & (wd_q == WD_W'(TIMEOUT - 1));
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (NSTAGE=5, REDIR_DEPTH=2, FLUSH_CYC=3,
// CNT_W=4, TIMEOUT=4).
module tb_pipe_ctrl;

   localparam int N  = 5;
   localparam int RD = 2;
   localparam int FC = 3;
   localparam int CW = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cnt_clr;
   logic          busy;
   logic [CW-1:0] scyc;
   logic          tmo;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.NSTAGE(N)) hz ();

   pipe_ctrl #(
      .NSTAGE(N), .REDIR_DEPTH(RD), .FLUSH_CYC(FC),
      .CNT_W(CW), .TIMEOUT(TO)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .hz             (hz),
      .cnt_clr_i      (cnt_clr),
      .busy_o         (busy),
      .stall_cycles_o (scyc),
      .timeout_o      (tmo)
   );

   typedef struct {
      logic [N-1:0]  stall;
      logic [N-1:0]  flush;
      logic          tmo;
      logic          busy;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   m_rem = 0;
   int   m_cnt = 0;
   int   m_wd  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic [N-1:0] sr, input logic rd,
                      input logic en, input logic clr,
                      input logic rs, input string tag);
      exp_t e;
      exp_t x;
      int   k;
      logic s0;
      rst          = rs;
      hz.stallreq  = sr;
      hz.redirect  = rd;
      hz.enter     = en;
      cnt_clr      = clr;
      k = 0;
      for (int i = 1; i < N; i++) if (sr[i]) k = i;
      e.stall = '0;
      e.flush = '0;
      e.tmo   = 1'b0;
      e.busy  = (m_rem > 0);
      e.cnt   = CW'(m_cnt);
      if (!rs) begin
         if (en || m_rem > 0) begin
            for (int i = 1; i < N; i++) e.flush[i] = 1'b1;
         end else if (rd && k < RD) begin
            for (int i = 1; i <= RD; i++) e.flush[i] = 1'b1;
         end else if (k > 0) begin
            for (int i = 0; i <= k; i++) e.stall[i] = 1'b1;
            if (k + 1 < N) e.flush[k+1] = 1'b1;
         end
      end
      s0 = e.stall[0];
`ifdef STALL_TIMEOUT_EN
      e.tmo = s0 && (m_wd == TO - 1);
`endif
      sb.push_back(e);
      @(negedge clk);
      x = sb.pop_front();
      chk({tag, ".stall"}, 32'(hz.stall), 32'(x.stall));
      chk({tag, ".flush"}, 32'(hz.flush), 32'(x.flush));
      chk({tag, ".tmo"},   32'(tmo),      32'(x.tmo));
      chk({tag, ".busy"},  32'(busy),     32'(x.busy));
      chk({tag, ".cnt"},   32'(scyc),     32'(x.cnt));
      @(posedge clk);
      if (rs) begin
         m_rem = 0;
         m_cnt = 0;
         m_wd  = 0;
      end else begin
         m_rem = en ? FC - 1 : ((m_rem > 0) ? m_rem - 1 : 0);
         if (clr) m_cnt = 0;
         else if (s0 && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
         m_wd = s0 ? ((m_wd < TO) ? m_wd + 1 : TO) : 0;
      end
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      hz.stallreq = '0;
      hz.redirect = 1'b0;
      hz.enter    = 1'b0;
      cnt_clr     = 1'b0;
      @(posedge clk);
      #1;
      // reset with garbage requests
      cyc(5'b11110, 1'b1, 1'b1, 1'b0, 1'b1, "rst0");
      cyc(5'b11110, 1'b0, 1'b1, 1'b0, 1'b1, "rst1");
      cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
      // load-use
      repeat (3) cyc(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, "ldu");
      cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, "ldu_end");
      // redirect cases
      cyc(5'b00010, 1'b1, 1'b0, 1'b0, 1'b0, "redir_lo");
      cyc(5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, "redir_none");
      cyc(5'b01000, 1'b1, 1'b0, 1'b0, 1'b0, "redir_hi");
      cyc(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, "redir_src");
      cyc(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0, "stall_top");
      // trap during stall
      cyc(5'b00100, 1'b0, 1'b1, 1'b0, 1'b0, "trap0");
      cyc(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0, "trap1");
      cyc(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, "trap2");
      cyc(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, "trap_done");
      // retrigger in second trap cycle
      cyc(5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, "rtr0");
      cyc(5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, "rtr1");
      repeat (4) cyc(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, "rtr_n");
      // clear wins over increment
      cyc(5'b00010, 1'b0, 1'b0, 1'b1, 1'b0, "clr");
      cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, "clr_end");
      // watchdog: 6 stalls, gap, 4 stalls
      repeat (6) cyc(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0, "wd_a");
      cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, "wd_gap");
      repeat (4) cyc(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, "wd_b");
      // counter saturation
      repeat (12) cyc(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, "sat");
      cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, "sat_end");
      // reset mid-trap and mid-stall
      cyc(5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, "mid_trap");
      cyc(5'b00100, 1'b0, 1'b0, 1'b0, 1'b1, "mid_rst");
      cyc(5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");
      // random mix
      for (int i = 0; i < 60; i++) begin
         cyc(N'($urandom), ($urandom % 4) == 0, ($urandom % 10) == 0,
             ($urandom % 16) == 0, ($urandom % 40) == 0, "rnd");
      end
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
